// File: rtl/leg_bus_pkg.sv
// rtl/leg_bus_pkg.sv - shared state encoding, default sizes and clog2 for the leg bus arbiter
package leg_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr, wrapping
module rr_pick import leg_bus_pkg::*; #(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = clog2(DEF_NUM_REQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  // sum is one bit wider so ptr+k never overflows before the modulo-N fold
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    j    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!any && req[j]) begin
        any     = 1'b1;
        idx     = j;
        pick[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leg_bus_arbiter.sv
// rtl/leg_bus_arbiter.sv - shared servo/neuron command bus arbiter with bounded grants.
// LEG_BUS_FIXED_PRIO_EN: replaces round robin with lowest-index-wins and drops the pointer.
module leg_bus_arbiter import leg_bus_pkg::*; #(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [clog2(NUM_REQ)-1:0]   out_src,
  input  logic                        out_ready
);

  localparam int SRC_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_HOLD + 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SRC_W-1:0]   src_q, src_d, src_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0] pick;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;

`ifdef LEG_BUS_FIXED_PRIO_EN
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_any && req[i]) begin
        pick_any = 1'b1;
        pick_idx = SRC_W'(i);
        pick[i]  = 1'b1;
      end
    end
  end
`else
  logic [SRC_W-1:0] ptr_q, ptr_d;

  rr_pick #(.N(NUM_REQ), .IW(SRC_W)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign src_inc = (src_q == SRC_W'(NUM_REQ - 1)) ? '0 : src_q + SRC_W'(1);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_data  = '0;
`ifndef LEG_BUS_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick;
          src_d   = pick_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        out_valid = req[src_q];
        if (out_valid) out_data = req_data[int'(src_q)*DATA_W +: DATA_W];
        // withdrawal, last beat or hold cap all end the grant; the pointer moves past the holder
        if (!req[src_q] ||
            (out_ready && (req_last[src_q] || cnt_inc == CNT_W'(MAX_HOLD)))) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifndef LEG_BUS_FIXED_PRIO_EN
          ptr_d   = src_inc;
`endif
        end
        if (out_valid && out_ready) cnt_d = cnt_inc;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign out_src = src_q;

endmodule

// File: tb/tb_leg_bus_arbiter.sv
// tb/tb_leg_bus_arbiter.sv - directed scoreboard bench for leg_bus_arbiter (4 req, 8-bit, hold 4)
module tb_leg_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_last, gnt;
  logic [31:0] req_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } beat_t;
  beat_t sbq[$];

  always #5 clk = ~clk;

  leg_bus_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic lane(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic expect_beat(input logic [1:0] s, input logic [7:0] d);
    beat_t b;
    b.src  = s;
    b.data = d;
    sbq.push_back(b);
  endtask

  task automatic mon();
    beat_t e;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_unexpected_beat", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("sb_src", 32'(out_src), 32'(e.src));
        chk("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  int g;

  initial begin
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; out_ready = 1'b1;
    tick(); settle();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    tick();
    rst = 1'b0;

    // idle bus stays at zero
    for (int c = 0; c < 20; c++) begin
      settle();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_valid", 32'(out_valid), 32'h0);
      chk("idle_data", 32'(out_data), 32'h0);
      mon(); tick();
    end

    // single three-beat burst from requester 2
    req = 4'b0100; lane(2, 8'hA1);
    settle(); chk("b_pre_gnt", 32'(gnt), 32'h0); mon(); tick();
    expect_beat(2'd2, 8'hA1);
    settle(); chk("b_gnt", 32'(gnt), 32'h4); chk("b_src", 32'(out_src), 32'd2); mon(); tick();
    lane(2, 8'hA2); expect_beat(2'd2, 8'hA2); settle(); mon(); tick();
    lane(2, 8'hA3); req_last = 4'b0100; expect_beat(2'd2, 8'hA3); settle(); mon(); tick();
    req = '0; req_last = '0;
    settle(); chk("b_release_gnt", 32'(gnt), 32'h0); mon(); tick();

    rst = 1'b1; tick(); rst = 1'b0;

    // round robin, two-beat bursts from everyone
    for (int k = 0; k < 5; k++) begin
      g = order[k];
      req = 4'b1111; req_last = '0;
      for (int i = 0; i < 4; i++) lane(i, 8'(8'h10 * i + 1));
      settle(); chk("rr_idle_gap", 32'(gnt), 32'h0); mon(); tick();
      expect_beat(2'(g), 8'(8'h10 * g + 1));
      settle(); chk("rr_gnt", 32'(gnt), 32'(1 << g)); chk("rr_src", 32'(out_src), 32'(g)); mon(); tick();
      for (int i = 0; i < 4; i++) lane(i, 8'(8'h10 * i + 2));
      req_last = 4'b1111; expect_beat(2'(g), 8'(8'h10 * g + 2));
      settle(); mon(); tick();
    end

    // hold cap: requester 1 streams without last, requester 3 competes
    req = 4'b1010; req_last = '0;
    settle(); chk("cap_idle", 32'(gnt), 32'h0); mon(); tick();
    for (int n = 1; n <= 4; n++) begin
      lane(1, 8'(8'hB0 + n)); expect_beat(2'd1, 8'(8'hB0 + n));
      settle(); chk("cap_gnt1", 32'(gnt), 32'h2); mon(); tick();
    end
    settle(); chk("cap_release", 32'(gnt), 32'h0); mon(); tick();
    lane(3, 8'hC1); req_last = 4'b1000; expect_beat(2'd3, 8'hC1);
    settle(); chk("cap_gnt3", 32'(gnt), 32'h8); mon(); tick();
    req_last = '0; req = 4'b0010;
    settle(); chk("cap_idle2", 32'(gnt), 32'h0); mon(); tick();
    for (int n = 5; n <= 8; n++) begin
      lane(1, 8'(8'hB0 + n)); expect_beat(2'd1, 8'(8'hB0 + n));
      settle(); chk("cap_gnt1b", 32'(gnt), 32'h2); mon(); tick();
    end
    settle(); chk("cap_release2", 32'(gnt), 32'h0); mon(); tick();
    for (int n = 9; n <= 10; n++) begin
      lane(1, 8'(8'hB0 + n)); req_last = (n == 10) ? 4'b0010 : 4'b0000;
      expect_beat(2'd1, 8'(8'hB0 + n));
      settle(); chk("cap_gnt1c", 32'(gnt), 32'h2); mon(); tick();
    end
    req = '0; req_last = '0;

    // backpressure then withdraw on requester 0
    req = 4'b0001;
    settle(); chk("bp_idle", 32'(gnt), 32'h0); mon(); tick();
    lane(0, 8'hD1); expect_beat(2'd0, 8'hD1);
    settle(); chk("bp_gnt", 32'(gnt), 32'h1); mon(); tick();
    out_ready = 1'b0; lane(0, 8'hD2);
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("stall_gnt", 32'(gnt), 32'h1);
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_data", 32'(out_data), 32'hD2);
      mon(); tick();
    end
    out_ready = 1'b1; expect_beat(2'd0, 8'hD2); settle(); mon(); tick();
    lane(0, 8'hD3); expect_beat(2'd0, 8'hD3);
    settle(); chk("bp_gnt_held", 32'(gnt), 32'h1); mon(); tick();
    req = '0; lane(0, 8'hD4);
    settle();
    chk("wd_valid", 32'(out_valid), 32'h0);
    chk("wd_data", 32'(out_data), 32'h0);
    chk("wd_gnt", 32'(gnt), 32'h1);
    mon(); tick();
    settle(); chk("wd_release", 32'(gnt), 32'h0); mon(); tick();

    // async reset mid-burst, then arbitration restarts at requester 0
    req = 4'b0100; out_ready = 1'b0; lane(2, 8'hE1);
    settle(); chk("ar_idle", 32'(gnt), 32'h0); mon(); tick();
    settle();
    chk("ar_gnt", 32'(gnt), 32'h4);
    chk("ar_valid", 32'(out_valid), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("ar_rst_gnt", 32'(gnt), 32'h0);
    chk("ar_rst_valid", 32'(out_valid), 32'h0);
    chk("ar_rst_data", 32'(out_data), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1; req = 4'b1111; req_last = '0;
    for (int i = 0; i < 4; i++) lane(i, 8'(8'h10 * i + 5));
    settle(); chk("ar_post_idle", 32'(gnt), 32'h0); mon(); tick();
    req_last = 4'b1111; expect_beat(2'd0, 8'h05);
    settle(); chk("ar_restart_gnt", 32'(gnt), 32'h1); mon(); tick();
    req = '0; req_last = '0;
    settle(); chk("ar_final_idle", 32'(gnt), 32'h0); mon(); tick();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leg_bus_arbiter.md
Name: leg_bus_arbiter

Overview:
- Round-robin arbiter sharing the single servo/neuron command bus between NUM_REQ leg controllers.
- Grants one requester at a time and forwards that requester's data beats over a valid/ready handshake.
- Bounds each grant to MAX_HOLD beats.
- Drives the bus to constant zero whenever no grant is active, so downstream servos see a safe zero command when idle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, command word width.
- MAX_HOLD, 4, maximum beats accepted per grant (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request/valid.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  final beat of the requester's burst.
- gnt  output  NUM_REQ  one-hot grant, registered.
- out_valid  output  1  bus beat valid.
- out_data  output  DATA_W  bus data; zero when out_valid is low.
- out_src  output  clog2(NUM_REQ)  index of the granted requester, registered.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, gnt=0, out_src=0, rr pointer=0, beat count=0. Therefore out_valid=0 and out_data=0.
- Reset asserted mid-burst aborts the burst immediately. No beat is counted as accepted in that cycle.
- FSM has two states:
  - IDLE: gnt=0. If any req bit is high, pick the first requester at or after the pointer (wrapping modulo NUM_REQ). On the next edge load gnt/out_src, clear the beat count and go to XFER. If no request, stay in IDLE.
  - XFER: out_valid = req[out_src] (combinational). out_data = req_data[out_src] when out_valid, else 0. A beat is accepted when out_valid && out_ready; on acceptance the beat count increments.
- XFER release conditions (any one):
  - an accepted beat with req_last[out_src]=1;
  - an accepted beat that brings the count to MAX_HOLD;
  - req[out_src]=0 (requester withdrew; no beat accepted that cycle).
- On release: pointer = out_src+1 (wraps at NUM_REQ); next edge gnt=0 and state=IDLE.
- Latency:
  - req rising in cycle N with the bus idle -> gnt high in cycle N+1.
  - First beat can be accepted in cycle N+1.
  - Every grant is followed by exactly one IDLE cycle. Release in cycle M -> earliest next grant in cycle M+2.
- Requests arriving while another requester is granted are held off until release; no preemption.
- A requester that keeps req high after a MAX_HOLD release re-enters round robin behind all other active requesters.
- out_ready low stalls the beat. Count and grant hold; data must stay stable by requester convention.
- gnt is always one-hot or zero. out_src holds its last value while in IDLE.

Optional Feature:
- Macro: LEG_BUS_FIXED_PRIO_EN.
- Defined: the IDLE selection is fixed priority, lowest index wins; the pointer register is removed. MAX_HOLD and the single IDLE gap still apply, so starvation is bounded only by the other requesters' behaviour.
- Undefined (default): round robin as described above.

Decomposition:
- Shared package/header leg_bus_pkg:
  - state encodings IDLE=1'b0, XFER=1'b1;
  - default NUM_REQ/DATA_W/MAX_HOLD constants;
  - clog2 function.
- One sub-module, rr_pick: combinational. Inputs: req vector and pointer. Outputs: one-hot pick, index and any-valid flag. It is bypassed (lowest-index picker) under LEG_BUS_FIXED_PRIO_EN.
- The FSM, counter and output mux stay in leg_bus_arbiter.

Test Plan (NUM_REQ=4, DATA_W=8, MAX_HOLD=4):
1. Reset then idle: rst pulse, req=0 -> gnt=0, out_valid=0, out_data=8'h00 for 20 cycles.
2. Single burst: req[2]=1, data 8'hA1,A2,A3 with req_last on the third beat, out_ready=1.
   - gnt=4'b0100 one cycle after req.
   - Three beats with out_src=2.
   - gnt=0 the cycle after the last beat.
3. Round robin: req=4'b1111 held, each requester sending bursts of 2 with last.
   - Grant order 0,1,2,3,0.
   - One idle cycle between consecutive grants.
4. MAX_HOLD cap: req[1] streams 10 beats with no last.
   - Released after beat 4.
   - With req[3] also high, the next grant goes to 3, then back to 1.
5. Backpressure/withdraw:
   - out_ready=0 for 3 cycles mid-burst -> beat count frozen, gnt held.
   - Then req[0] dropped -> release with no beat accepted and out_data=0 that cycle.
6. Async reset mid-burst: rst asserted between clock edges during XFER -> gnt, out_valid and out_data are 0 immediately. After release, arbitration restarts from pointer 0.
